// File: rtl/hash_hit_merger_pkg.sv
// Shared types for the hash hit merger: FIFO entry layout and per-lane byte-position offsets.
package hash_hit_merger_pkg;

    localparam int NBITS = 15;
    localparam int POS_W = 16;

    localparam logic [POS_W-1:0] LANE0_OFS = POS_W'(0);
    localparam logic [POS_W-1:0] LANE1_OFS = POS_W'(1);
    localparam logic [POS_W-1:0] STEP_ADV  = POS_W'(2);

    typedef struct packed {
        logic [NBITS-1:0] idx;
        logic [POS_W-1:0] pos;
        logic             is_hit;
        logic             last;
    } hit_entry_t;

endpackage

// File: rtl/hash_hit_merger_if.sv
// Hit-stream input and serialised verification-stream output of the hash hit merger.
interface hash_hit_merger_if #(
    parameter int DROP_W = 16
);
    import hash_hit_merger_pkg::*;

    logic [NBITS-1:0]  hit0_idx;
    logic              hit0_valid;
    logic [NBITS-1:0]  hit1_idx;
    logic              hit1_valid;
    logic              hit_step;
    logic              hit_eop;
    logic [NBITS-1:0]  out_idx;
    logic [POS_W-1:0]  out_pos;
    logic              out_is_hit;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              almost_full;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output hit0_idx, hit0_valid, hit1_idx, hit1_valid, hit_step, hit_eop, out_ready,
        input  out_idx, out_pos, out_is_hit, out_last, out_valid, almost_full, overflow, drop_cnt
    );

    modport slave (
        input  hit0_idx, hit0_valid, hit1_idx, hit1_valid, hit_step, hit_eop, out_ready,
        output out_idx, out_pos, out_is_hit, out_last, out_valid, almost_full, overflow, drop_cnt
    );

endinterface

// File: rtl/hash_hit_merger_fifo_2w1r.sv
// Two-write / one-read FIFO of hit entries with a registered first-word-fall-through head.
// wr1_en is only ever raised together with wr0_en; port 1 lands in the slot after port 0.
module hash_hit_merger_fifo_2w1r
    import hash_hit_merger_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr0_en,
    input  hit_entry_t    wr0_data,
    input  logic          wr1_en,
    input  hit_entry_t    wr1_data,
    input  logic          rd_en,
    output hit_entry_t    head_p1,
    output logic          vld_p1,
    output logic [CW-1:0] count
);

    hit_entry_t    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [1:0]    nwr;
    logic          pop;

    always_comb begin
        nwr = {1'b0, wr0_en} + {1'b0, wr1_en};
        pop = rd_en & vld_p1;
    end

    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr] <= wr0_data;
        if (wr1_en) mem[wr_ptr + AW'(1)] <= wr1_data;
    end

    // head register: shows the oldest entry already in storage, held until popped
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            vld_p1  <= 1'b0;
            head_p1 <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            wr_ptr <= wr_ptr + AW'(nwr);
            count  <= count + CW'(nwr) - CW'(pop);
            vld_p1 <= (count != CW'(pop));
            if (count != CW'(pop)) head_p1 <= mem[rd_ptr + AW'(pop)];
        end
    end

endmodule

// File: rtl/hash_hit_merger.sv
// Serialises the two-lane bitmap-hit stream into one tagged valid/ready stream with
// byte positions, end-of-packet marking, overflow accounting and an almost-full stall hint.
module hash_hit_merger
    import hash_hit_merger_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4,
    parameter int DROP_W    = 16,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    hash_hit_merger_if.slave  hb
);

    logic [POS_W-1:0]  pos_cnt;
    logic              c0, c1, mk, eop_step, pop;
    logic [1:0]        ncand, nfit, ndrop;
    logic [CW-1:0]     count, free, count_nxt;
    hit_entry_t        wr0_data, wr1_data, head_p1;
    logic              wr0_en, wr1_en, vld_p1;
    logic              almost_full, overflow;
    logic [DROP_W-1:0] drop_cnt;

    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] acc,
                                                        input logic [1:0]        inc);
        logic [DROP_W:0] sum;
        sum = {1'b0, acc} + (DROP_W+1)'(inc);
        return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    endfunction

    always_comb begin
        c0       = hb.hit_step & hb.hit0_valid;
        c1       = hb.hit_step & hb.hit1_valid;
        eop_step = hb.hit_step & hb.hit_eop;
        mk       = eop_step & ~c0 & ~c1;
        ncand    = {1'b0, c0} + {1'b0, c1} + {1'b0, mk};
        pop      = vld_p1 & hb.out_ready;
        // a pop this cycle frees a slot for a same-cycle write, even when full
        free      = CW'(DEPTH) - count + CW'(pop);
        nfit      = (free >= CW'(ncand)) ? ncand : free[1:0];
        ndrop     = ncand - nfit;
        count_nxt = count + CW'(nfit) - CW'(pop);
        wr0_en    = (nfit != 2'd0);
        wr1_en    = (nfit == 2'd2);

        wr0_data        = '0;
        wr0_data.idx    = c0 ? hb.hit0_idx : (c1 ? hb.hit1_idx : '0);
        wr0_data.pos    = (c0 || mk) ? pos_cnt + LANE0_OFS : pos_cnt + LANE1_OFS;
        wr0_data.is_hit = c0 | c1;
        wr0_data.last   = eop_step & (nfit == 2'd1);

        wr1_data        = '0;
        wr1_data.idx    = hb.hit1_idx;
        wr1_data.pos    = pos_cnt + LANE1_OFS;
        wr1_data.is_hit = 1'b1;
        wr1_data.last   = eop_step;
    end

    hash_hit_merger_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (hb.out_ready),
        .head_p1  (head_p1),
        .vld_p1   (vld_p1),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_cnt     <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (hb.hit_step) pos_cnt <= hb.hit_eop ? '0 : pos_cnt + STEP_ADV;
            almost_full <= (count_nxt >= CW'(DEPTH - AF_MARGIN));
            if (ndrop != 2'd0) overflow <= 1'b1;
            drop_cnt <= sat_add_drop(drop_cnt, ndrop);
        end
    end

    assign hb.out_idx     = head_p1.idx;
    assign hb.out_pos     = head_p1.pos;
    assign hb.out_is_hit  = head_p1.is_hit;
    assign hb.out_last    = head_p1.last;
    assign hb.out_valid   = vld_p1;
    assign hb.almost_full = almost_full;
    assign hb.overflow    = overflow;
    assign hb.drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_hash_hit_merger.sv
// Directed bench for hash_hit_merger: single hits, dual hits with EOP, EOP markers,
// overflow with drops, push+pop at full, and mid-packet reset.
module tb_hash_hit_merger;
    import hash_hit_merger_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hash_hit_merger_if #(.DROP_W(16)) bus ();

    hash_hit_merger #(.DEPTH(16), .AF_MARGIN(4), .DROP_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hb  (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [14:0] idx, input logic [15:0] pos,
                            input logic hit, input logic last);
        chk(tag, {30'd0, bus.out_valid, bus.out_idx, bus.out_pos, bus.out_is_hit, bus.out_last},
                 {30'd0, 1'b1, idx, pos, hit, last});
    endtask

    task automatic drive(input logic v0, input logic [14:0] i0, input logic v1,
                         input logic [14:0] i1, input logic eop);
        bus.hit_step   = 1'b1;
        bus.hit0_valid = v0;
        bus.hit0_idx   = i0;
        bus.hit1_valid = v1;
        bus.hit1_idx   = i1;
        bus.hit_eop    = eop;
        tick();
        bus.hit_step   = 1'b0;
        bus.hit0_valid = 1'b0;
        bus.hit1_valid = 1'b0;
        bus.hit_eop    = 1'b0;
    endtask

    task automatic dual(input int k);
        drive(1'b1, 15'(16'h100 + 2 * k), 1'b1, 15'(16'h101 + 2 * k), 1'b0);
    endtask

    initial begin
        bus.hit_step   = 1'b0;
        bus.hit0_valid = 1'b0;
        bus.hit1_valid = 1'b0;
        bus.hit0_idx   = '0;
        bus.hit1_idx   = '0;
        bus.hit_eop    = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) tick();

        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_af",    64'(bus.almost_full), 64'd0);
        chk("rst_ovf",   64'(bus.overflow), 64'd0);
        chk("rst_drop",  64'(bus.drop_cnt), 64'd0);
        chk("rst_data",  64'({bus.out_idx, bus.out_pos, bus.out_is_hit, bus.out_last}), 64'd0);
        rst = 1'b0;

        // single lane-0 hit at packet start
        drive(1'b1, 15'h0123, 1'b0, 15'h0, 1'b0);
        chk("t1_lat1", 64'(bus.out_valid), 64'd0);
        tick();
        chk_head("t1_head", 15'h0123, 16'd0, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t1_empty", 64'(bus.out_valid), 64'd0);

        // two idle windows (pos 2 -> 6), then dual hit with EOP
        drive(1'b0, 15'h0, 1'b0, 15'h0, 1'b0);
        drive(1'b0, 15'h0, 1'b0, 15'h0, 1'b0);
        drive(1'b1, 15'd5, 1'b1, 15'd9, 1'b1);
        tick();
        chk_head("t2_first", 15'd5, 16'd6, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        chk_head("t2_second", 15'd9, 16'd7, 1'b1, 1'b1);
        tick();
        chk("t2_empty", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // pos restarted at 0; five idle windows reach pos 10, then an EOP with no hits
        for (int i = 0; i < 5; i++) drive(1'b0, 15'h0, 1'b0, 15'h0, 1'b0);
        drive(1'b0, 15'h0, 1'b0, 15'h0, 1'b1);
        tick();
        chk_head("t3_marker", 15'd0, 16'd10, 1'b0, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t3_empty", 64'(bus.out_valid), 64'd0);

        // fill with the consumer stalled: 9 dual windows into 16 slots
        for (int k = 0; k < 5; k++) dual(k);
        chk("t4_af_at10", 64'(bus.almost_full), 64'd0);
        dual(5);
        chk("t4_af_at12", 64'(bus.almost_full), 64'd1);
        dual(6);
        dual(7);
        chk("t4_ovf_at16", 64'(bus.overflow), 64'd0);
        chk("t4_drop_at16", 64'(bus.drop_cnt), 64'd0);
        dual(8);
        chk("t4_ovf", 64'(bus.overflow), 64'd1);
        chk("t4_drop", 64'(bus.drop_cnt), 64'd2);
        chk_head("t4_head", 15'h100, 16'd0, 1'b1, 1'b0);

        // full FIFO: a push and a pop in the same cycle, no drop
        bus.out_ready = 1'b1;
        drive(1'b1, 15'h1FF, 1'b0, 15'h0, 1'b0);
        chk("t5_drop", 64'(bus.drop_cnt), 64'd2);
        chk("t5_af", 64'(bus.almost_full), 64'd1);
        chk_head("t5_head", 15'h101, 16'd1, 1'b1, 1'b0);
        tick();
        for (int k = 1; k < 8; k++) begin
            chk_head("t4_drain_l0", 15'(16'h100 + 2 * k), 16'(2 * k), 1'b1, 1'b0);
            tick();
            chk_head("t4_drain_l1", 15'(16'h101 + 2 * k), 16'(2 * k + 1), 1'b1, 1'b0);
            tick();
        end
        chk_head("t5_tail", 15'h1FF, 16'd18, 1'b1, 1'b0);
        tick();
        chk("t5_empty", 64'(bus.out_valid), 64'd0);
        chk("t5_af_clr", 64'(bus.almost_full), 64'd0);
        chk("t5_ovf_sticky", 64'(bus.overflow), 64'd1);
        bus.out_ready = 1'b0;

        // queue 5 entries mid-packet, then reset
        drive(1'b1, 15'h201, 1'b1, 15'h202, 1'b0);
        drive(1'b1, 15'h203, 1'b1, 15'h204, 1'b0);
        drive(1'b0, 15'h0, 1'b1, 15'h205, 1'b0);
        chk_head("t6_pre", 15'h201, 16'd20, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_drop", 64'(bus.drop_cnt), 64'd0);
        chk("t6_ovf", 64'(bus.overflow), 64'd0);
        chk("t6_af", 64'(bus.almost_full), 64'd0);
        rst = 1'b0;
        drive(1'b1, 15'h077, 1'b0, 15'h0, 1'b1);
        chk("t6_lat1", 64'(bus.out_valid), 64'd0);
        tick();
        chk_head("t6_restart", 15'h077, 16'd0, 1'b1, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        chk("t6_no_stale", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t6_still_empty", 64'(bus.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
